// File: rtl/router_inject_sched_pkg.sv
// Shared definitions for the injection scheduler: channel and credit-return
// field offsets, FSM state encoding and a constant clog2 helper.
package router_inject_sched_pkg;

  // Channel word, LSB first: valid, head, tail, vc, then payload.
  localparam int chan_valid_bit = 0;
  localparam int chan_head_bit  = 1;
  localparam int chan_tail_bit  = 2;
  localparam int chan_vc_lsb    = 3;

  // Credit return word, LSB first: valid, then vc.
  localparam int fc_valid_bit = 0;
  localparam int fc_vc_lsb    = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } inj_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/inj_rr_arbiter.sv
// Round-robin request/grant arbiter. The pointer names the highest-priority
// index; on an enabled grant it moves to the slot after the winner.
module inj_rr_arbiter #(
  parameter int num_requesters = 4,
  parameter int idx_width      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [num_requesters-1:0] req,
  input  logic                      update,
  output logic                      grant_valid,
  output logic [idx_width-1:0]      grant_idx,
  output logic [idx_width-1:0]      rr_ptr
);

  int                   cand;
  logic [idx_width-1:0] cand_idx;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < num_requesters; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= num_requesters) cand = cand - num_requesters;
      cand_idx = idx_width'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Advance the pointer past the winner only when a grant is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (update && grant_valid) begin
      rr_ptr <= (grant_idx == idx_width'(num_requesters - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/router_inject_sched.sv
// Injection scheduler: wormhole round-robin over local sources onto one
// router input channel, with per-VC credit tracking and a sticky error flag.
//
// Source handshake: a flit transfers in a cycle where src_valid[i] and
// src_ready[i] are both high; src_ready never depends on src_data and the
// source must hold its flit stable until it transfers. The accepted flit
// appears on channel_out exactly one cycle later.
module router_inject_sched
  import router_inject_sched_pkg::*;
#(
  parameter int num_requesters  = 4,
  parameter int num_vcs         = 2,
  parameter int vc_idx_width    = 1,
  parameter int flit_data_width = 64,
  parameter int buf_depth       = 8,
  parameter int channel_width   = 3 + vc_idx_width + flit_data_width,
  parameter int flow_ctrl_width = 1 + vc_idx_width
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [num_requesters-1:0]                 src_valid,
  input  logic [num_requesters-1:0]                 src_head,
  input  logic [num_requesters-1:0]                 src_tail,
  input  logic [num_requesters*vc_idx_width-1:0]    src_vc,
  input  logic [num_requesters*flit_data_width-1:0] src_data,
  output logic [num_requesters-1:0]                 src_ready,
  output logic [channel_width-1:0]                  channel_out,
  input  logic [flow_ctrl_width-1:0]                flow_ctrl_in,
  output logic                                      error
);

  localparam int cred_width    = clog2(buf_depth + 1);
  localparam int req_idx_width = (num_requesters > 1) ? clog2(num_requesters) : 1;
  localparam int data_lsb      = chan_vc_lsb + vc_idx_width;
  localparam logic [cred_width-1:0] cred_max = cred_width'(buf_depth);

  inj_state_e                         state, state_next;
  logic [num_vcs-1:0][cred_width-1:0] credits;
  logic [req_idx_width-1:0]           locked_src;
  logic [vc_idx_width-1:0]            locked_vc;
  logic [num_requesters-1:0]          eligible;
  logic [num_requesters-1:0]          arb_req;
  logic                               grant_valid;
  logic [req_idx_width-1:0]           grant_idx;
  logic [req_idx_width-1:0]           rr_ptr;
  logic                               send;
  logic [req_idx_width-1:0]           send_src;
  logic [vc_idx_width-1:0]            send_vc;
  logic                               send_head;
  logic                               send_tail;
  logic [flit_data_width-1:0]         send_data;
  logic [vc_idx_width-1:0]            grant_vc;
  logic                               proto_err;
  logic                               fc_valid;
  logic [vc_idx_width-1:0]            fc_vc;
  logic [num_vcs-1:0]                 cred_inc;
  logic [num_vcs-1:0]                 cred_dec;
  logic [num_vcs-1:0]                 cred_ovf;

  assign fc_valid = flow_ctrl_in[fc_valid_bit];
  assign fc_vc    = flow_ctrl_in[fc_vc_lsb +: vc_idx_width];

  // A head is eligible only if its VC has a downstream slot; packet starts
  // are arbitrated only while no packet holds the channel.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < num_requesters; i++) begin
      eligible[i] = src_valid[i] & src_head[i] &
                    (credits[src_vc[i*vc_idx_width +: vc_idx_width]] != '0);
    end
    arb_req = (state == IDLE) ? eligible : '0;
  end

  inj_rr_arbiter #(
    .num_requesters (num_requesters),
    .idx_width      (req_idx_width)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (arb_req),
    .update      (state == IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .rr_ptr      (rr_ptr)
  );

  // Select the VC and payload of the granted/locked source.
  always_comb begin
    grant_vc  = '0;
    send_data = '0;
    for (int i = 0; i < num_requesters; i++) begin
      if (grant_idx == req_idx_width'(i)) grant_vc = src_vc[i*vc_idx_width +: vc_idx_width];
      if (send_src == req_idx_width'(i)) send_data = src_data[i*flit_data_width +: flit_data_width];
    end
  end

  // FSM next state, ready generation and the flit to send this cycle.
  always_comb begin
    state_next = state;
    src_ready  = '0;
    send       = 1'b0;
    send_src   = '0;
    send_vc    = '0;
    send_head  = 1'b0;
    send_tail  = 1'b0;
    proto_err  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          src_ready[grant_idx] = 1'b1;
          send      = 1'b1;
          send_src  = grant_idx;
          send_vc   = grant_vc;
          send_head = 1'b1;
          send_tail = src_tail[grant_idx];
          if (!send_tail) state_next = XFER;
        end
        // A body flit waiting at the front of the rotation has no packet.
        if (src_valid[rr_ptr] && !src_head[rr_ptr]) proto_err = 1'b1;
      end
      XFER: begin
        // A second head inside a packet is flagged and forwarded as body.
        if (src_valid[locked_src] && src_head[locked_src]) proto_err = 1'b1;
        if (src_valid[locked_src] && credits[locked_vc] != '0) begin
          src_ready[locked_src] = 1'b1;
          send      = 1'b1;
          send_src  = locked_src;
          send_vc   = locked_vc;
          send_tail = src_tail[locked_src];
          if (send_tail) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the packet lock taken on a head grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      locked_src <= '0;
      locked_vc  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_valid) begin
        locked_src <= grant_idx;
        locked_vc  <= grant_vc;
      end
    end
  end

  // Register the outgoing flit; idle cycles drive an all-zero word.
  always_ff @(posedge clk) begin
    if (reset) begin
      channel_out <= '0;
    end else begin
      channel_out <= '0;
      if (send) begin
        channel_out[chan_valid_bit]                <= 1'b1;
        channel_out[chan_head_bit]                 <= send_head;
        channel_out[chan_tail_bit]                 <= send_tail;
        channel_out[chan_vc_lsb +: vc_idx_width]   <= send_vc;
        channel_out[data_lsb +: flit_data_width]   <= send_data;
      end
    end
  end

  // Per-VC credit events; a return and a send on one VC cancel out.
  always_comb begin
    cred_inc = '0;
    cred_dec = '0;
    cred_ovf = '0;
    for (int v = 0; v < num_vcs; v++) begin
      cred_inc[v] = fc_valid && (fc_vc == vc_idx_width'(v));
      cred_dec[v] = send && (send_vc == vc_idx_width'(v));
      cred_ovf[v] = cred_inc[v] && !cred_dec[v] && (credits[v] == cred_max);
    end
  end

  // Credit counters saturate at the router buffer depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < num_vcs; v++) credits[v] <= cred_max;
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        if (cred_inc[v] && !cred_dec[v] && credits[v] != cred_max) begin
          credits[v] <= credits[v] + 1'b1;
        end else if (cred_dec[v] && !cred_inc[v]) begin
          credits[v] <= credits[v] - 1'b1;
        end
      end
    end
  end

  // Sticky error until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (proto_err || (|cred_ovf)) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_inject_sched.sv
// Directed bench for router_inject_sched: per-source packet model drives the
// sources, a queue of expected channel words checks the one-cycle output.
module tb_router_inject_sched;
  import router_inject_sched_pkg::*;

  localparam int nr = 4;
  localparam int vw = 1;
  localparam int dw = 64;
  localparam int cw = 3 + vw + dw;

  logic              clk = 1'b0;
  logic              reset;
  logic [nr-1:0]     src_valid, src_head, src_tail, src_ready;
  logic [nr*vw-1:0]  src_vc;
  logic [nr*dw-1:0]  src_data;
  logic [cw-1:0]     channel_out;
  logic [1+vw-1:0]   flow_ctrl_in;
  logic              error;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;
  logic [cw-1:0] exp_q[$];
  bit            after_reset = 1'b0;

  int            pk_len[nr];
  int            pk_idx[nr];
  bit            pk_act[nr];
  logic [vw-1:0] pk_vc[nr];
  logic [dw-1:0] pk_base[nr];

  router_inject_sched dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_head     (src_head),
    .src_tail     (src_tail),
    .src_vc       (src_vc),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [cw-1:0] flit_word(input int i);
    logic [cw-1:0] w;
    w = '0;
    w[0] = 1'b1;
    w[1] = (pk_idx[i] == 0);
    w[2] = (pk_idx[i] == pk_len[i] - 1);
    w[3 +: vw] = pk_vc[i];
    w[3 + vw +: dw] = pk_base[i] + dw'(pk_idx[i]);
    return w;
  endfunction

  task automatic drive();
    for (int i = 0; i < nr; i++) begin
      src_valid[i]          = pk_act[i];
      src_head[i]           = pk_act[i] && (pk_idx[i] == 0);
      src_tail[i]           = pk_act[i] && (pk_idx[i] == pk_len[i] - 1);
      src_vc[i*vw +: vw]    = pk_vc[i];
      src_data[i*dw +: dw]  = pk_base[i] + dw'(pk_idx[i]);
    end
  endtask

  task automatic start_pkt(input int i, input int len, input logic [vw-1:0] vc, input logic [dw-1:0] base);
    pk_len[i]  = len;
    pk_idx[i]  = 0;
    pk_vc[i]   = vc;
    pk_base[i] = base;
    pk_act[i]  = 1'b1;
    drive();
  endtask

  task automatic abort_all();
    for (int i = 0; i < nr; i++) pk_act[i] = 1'b0;
    drive();
  endtask

  // One clock: check the registered channel word and the ready vector,
  // record handshakes, then advance the source model after the edge.
  task automatic tick(input logic [nr-1:0] exp_rdy, input bit chk_rdy);
    logic [nr-1:0] hs;
    @(negedge clk);
    if (after_reset) chk("chan_after_reset", channel_out, '0);
    else if (exp_q.size() > 0) chk("chan_flit", channel_out, exp_q.pop_front());
    else chk("chan_bubble_valid", channel_out[0], 1'b0);
    after_reset = 1'b0;
    if (chk_rdy) chk("src_ready", src_ready, exp_rdy);
    hs = reset ? '0 : (src_valid & src_ready);
    for (int i = 0; i < nr; i++) if (hs[i]) exp_q.push_back(flit_word(i));
    @(posedge clk);
    #1;
    if (reset) begin
      after_reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < nr; i++) pk_act[i] = 1'b0;
    end else begin
      for (int i = 0; i < nr; i++) begin
        if (hs[i]) begin
          pk_idx[i]++;
          if (pk_idx[i] == pk_len[i]) pk_act[i] = 1'b0;
        end
      end
    end
    flow_ctrl_in = '0;
    drive();
  endtask

  initial begin
    reset        = 1'b1;
    flow_ctrl_in = '0;
    src_valid    = '0;
    src_head     = '0;
    src_tail     = '0;
    src_vc       = '0;
    src_data     = '0;
    for (int i = 0; i < nr; i++) begin
      pk_act[i] = 1'b0; pk_len[i] = 1; pk_idx[i] = 0; pk_vc[i] = '0; pk_base[i] = '0;
    end
    drive();

    // Reset state
    tick('0, 1'b0);
    reset = 1'b0;
    chk("rst_state", dut.state, IDLE);
    chk("rst_cred0", dut.credits[0], 4'd8);
    chk("rst_cred1", dut.credits[1], 4'd8);
    chk("rst_error", error, 1'b0);
    chk("rst_rr", dut.rr_ptr, 2'd0);

    // Single-flit packet from src 2 on vc 1
    start_pkt(2, 1, 1'b1, 64'hA5);
    tick(4'b0100, 1'b1);
    chk("t1_chan", channel_out, 68'hA5F);
    chk("t1_cred1", dut.credits[1], 4'd7);
    chk("t1_cred0", dut.credits[0], 4'd8);
    chk("t1_state", dut.state, IDLE);
    chk("t1_rr", dut.rr_ptr, 2'd3);
    tick(4'b0000, 1'b1);

    // Four 3-flit vc 0 packets: grants 0,1,2 then stall on credits
    reset = 1'b1;
    tick('0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < nr; i++) start_pkt(i, 3, 1'b0, 64'((i + 1) * 'h1000));
    tick(4'b0001, 1'b1);
    tick(4'b0001, 1'b1);
    tick(4'b0001, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0100, 1'b1);
    tick(4'b0100, 1'b1);
    chk("t2_cred0_empty", dut.credits[0], 4'd0);
    tick(4'b0000, 1'b1);
    chk("t2_stall_state", dut.state, XFER);
    chk("t2_stall_lock", dut.locked_src, 2'd2);
    flow_ctrl_in = 2'b01;
    tick(4'b0000, 1'b1);
    chk("t2_cred0_ret", dut.credits[0], 4'd1);
    tick(4'b0100, 1'b1);
    chk("t2_tail_chan", channel_out, 68'h30025);
    chk("t2_state_idle", dut.state, IDLE);
    chk("t2_rr", dut.rr_ptr, 2'd3);
    tick(4'b0000, 1'b1);

    // vc 0 empty: src 0 skipped, src 1 on vc 1 granted
    start_pkt(0, 2, 1'b0, 64'h5000);
    start_pkt(1, 1, 1'b1, 64'h6000);
    tick(4'b0010, 1'b1);
    chk("t3_chan", channel_out, 68'h6000F);
    chk("t3_cred1", dut.credits[1], 4'd7);
    chk("t3_rr", dut.rr_ptr, 2'd2);
    tick(4'b0000, 1'b1);
    abort_all();

    // Same-cycle return and send on vc 1, then overflow
    start_pkt(1, 1, 1'b1, 64'h7000);
    flow_ctrl_in = 2'b11;
    tick(4'b0010, 1'b1);
    chk("t4_cred1_net", dut.credits[1], 4'd7);
    chk("t4_error_clear", error, 1'b0);
    flow_ctrl_in = 2'b11;
    tick(4'b0000, 1'b1);
    chk("t4_cred1_full", dut.credits[1], 4'd8);
    chk("t4_error_still_clear", error, 1'b0);
    flow_ctrl_in = 2'b11;
    tick(4'b0000, 1'b1);
    chk("t4_cred1_sat", dut.credits[1], 4'd8);
    chk("t4_error_set", error, 1'b1);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    chk("t4_error_held", error, 1'b1);

    // Reset during the second flit of a 4-flit packet
    start_pkt(1, 4, 1'b1, 64'h8000);
    tick(4'b0010, 1'b1);
    chk("t5_state_xfer", dut.state, XFER);
    reset = 1'b1;
    tick(4'b0010, 1'b1);
    reset = 1'b0;
    chk("t5_state", dut.state, IDLE);
    chk("t5_cred0", dut.credits[0], 4'd8);
    chk("t5_cred1", dut.credits[1], 4'd8);
    chk("t5_error", error, 1'b0);
    chk("t5_rr", dut.rr_ptr, 2'd0);
    chk("t5_chan", channel_out, 68'h0);
    start_pkt(0, 1, 1'b1, 64'h9000);
    start_pkt(3, 1, 1'b1, 64'hB000);
    tick(4'b0001, 1'b1);
    chk("t5_new_head", channel_out, 68'h9000F);
    tick(4'b1000, 1'b1);
    chk("t5_next_head", channel_out, 68'hB000F);
    tick(4'b0000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
